// File: rtl/button_debounce.sv
// Purpose: per-channel push-button conditioner: synchroniser, debounce counter + FSM, clean level and press/release pulses.
// Latency: clean raw edge to level/rise/fall is SYNC_STAGES+STABLE_CYCLES clock edges; all outputs registered.
// Backpressure: none; pulses are single-cycle and must be consumed when they appear.
// Optional feature: define DEBOUNCE_REPEAT_EN to add auto-repeat rise pulses while a button stays held.
module button_debounce #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    // Elaboration-time sanity checks on the configuration.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("button_debounce: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debounce: SYNC_STAGES must be >= 2");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
        $error("button_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    // The stability counter only ever reaches STABLE_CYCLES-1 before a decision is made.
    localparam int                CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

`ifdef DEBOUNCE_REPEAT_EN
    localparam int                REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                RCNT_W     = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [RCNT_W-1:0] REP_DLY_M1 = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] REP_PER_M1 = RCNT_W'(REPEAT_PERIOD - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE   = RCNT_W'(1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM_PRS = 2'd1,
        ST_HELD    = 2'd2,
        ST_ARM_REL = 2'd3
    } state_t;

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];

    // Synchroniser chain: raw is asynchronous, the last stage feeds the FSMs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_level;
        logic             r_rise;
        logic             r_fall;
        logic             w_level_nxt;
        logic             w_rise_nxt;
        logic             w_fall_nxt;
        logic             w_s;
        logic             w_rep_fire;

        assign w_s = r_sync[SYNC_STAGES-1][g];

`ifdef DEBOUNCE_REPEAT_EN
        logic [RCNT_W-1:0] r_rcnt;
        logic              r_rfirst;
        logic [RCNT_W-1:0] w_rep_lim;

        // First repeat waits the long delay, later repeats use the short period.
        assign w_rep_lim  = r_rfirst ? REP_DLY_M1 : REP_PER_M1;
        assign w_rep_fire = (r_state == ST_HELD) && (r_rcnt == w_rep_lim);

        // Repeat counter: runs in HELD, freezes in ARM_REL, cleared whenever not pressed.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_rcnt   <= '0;
                r_rfirst <= 1'b1;
            end else begin
                case (r_state)
                    ST_HELD: begin
                        if (w_rep_fire) begin
                            r_rcnt   <= '0;
                            r_rfirst <= 1'b0;
                        end else begin
                            r_rcnt   <= r_rcnt + RCNT_ONE;
                        end
                    end
                    ST_ARM_REL: begin
                        r_rcnt   <= r_rcnt;
                        r_rfirst <= r_rfirst;
                    end
                    default: begin
                        r_rcnt   <= '0;
                        r_rfirst <= 1'b1;
                    end
                endcase
            end
        end
`else
        assign w_rep_fire = 1'b0;
`endif

        // State, stability counter and registered outputs.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
            end
        end

        // Debounce decision: any opposite sample while arming falls back to the stable state.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        w_state_nxt = ST_ARM_PRS;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                ST_ARM_PRS: begin
                    if (!w_s) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    w_rise_nxt = w_rep_fire;
                    if (!w_s) begin
                        w_state_nxt = ST_ARM_REL;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                ST_ARM_REL: begin
                    if (w_s) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
        end

        assign level[g] = r_level;
        assign rise[g]  = r_rise;
        assign fall[g]  = r_fall;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: expected pulses are queued with their due edge and
// compared by a negedge monitor; levels are checked inline by the stimulus sequence.
module tb_button_debounce;

    logic       clock;
    logic       reset;
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  n_edge   = 0;
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 0;

    button_debounce dut (
        .clock (clock),
        .reset (reset),
        .raw   (raw),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) n_edge = n_edge + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, expv, n_edge);
    endtask

    // Expected pulse due 'dly' edges after the current one.
    task automatic push(input int dly, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.cyc  = n_edge + dly;
        e.rise = r;
        e.fall = f;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Pulse monitor: every pulse must land exactly on its due edge, nothing else may pulse.
    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == n_edge) begin
                mon_ev = exp_q.pop_front();
                chk("rise_pulse", 32'(rise), 32'(mon_ev.rise));
                chk("fall_pulse", 32'(fall), 32'(mon_ev.fall));
            end else if ((rise | fall) !== 4'h0) begin
                chk("stray_pulse", 32'({rise, fall}), 32'h0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        raw   = 4'h0;

        // 1: reset held three cycles, outputs idle afterwards
        step(3);
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_idle", 32'({level, rise, fall}), 32'h0);
            step(1);
        end

        // 2: single press/release on channel 0
        raw[0] = 1'b1;
        push(10, 4'b0001, 4'b0000);
        step(9);
        chk("t2_level_before", 32'(level), 32'h0);
        step(1);
        chk("t2_level_after", 32'(level), 32'h1);
        step(10);
        chk("t2_level_hold", 32'(level), 32'h1);
        raw[0] = 1'b0;
        push(10, 4'b0000, 4'b0001);
        step(9);
        chk("t2_rel_before", 32'(level), 32'h1);
        step(1);
        chk("t2_rel_after", 32'(level), 32'h0);
        step(3);

        // 3: short press on ch1 and bouncing ch2 that finally settles high
        raw[1] = 1'b1; raw[2] = 1'b1;
        step(3); raw[2] = 1'b0;
        step(2); raw[1] = 1'b0;
        step(1); raw[2] = 1'b1;
        step(3); raw[2] = 1'b0;
        step(3); raw[2] = 1'b1;
        push(10, 4'b0100, 4'b0000);
        step(9);
        chk("t3_level_before", 32'(level), 32'h0);
        step(3);
        chk("t3_level_after", 32'(level), 32'h4);
        raw[2] = 1'b0;
        push(10, 4'b0000, 4'b0100);
        step(12);
        chk("t3_level_rel", 32'(level), 32'h0);

        // 4: all channels pressed on one edge
        raw = 4'hF;
        push(10, 4'b1111, 4'b0000);
        step(10);
        chk("t4_level_all", 32'(level), 32'hF);
        step(1);
        raw = 4'h0;
        push(10, 4'b0000, 4'b1111);
        step(10);
        chk("t4_level_none", 32'(level), 32'h0);
        step(2);

        // 5: reset mid-count on ch3 discards the count, press restarts after reset
        raw[3] = 1'b1;
        step(7);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t5_level_reset", 32'(level), 32'h0);
        push(10, 4'b1000, 4'b0000);
        step(9);
        chk("t5_level_before", 32'(level), 32'h0);
        step(1);
        chk("t5_level_after", 32'(level), 32'h8);
        raw[3] = 1'b0;
        push(10, 4'b0000, 4'b1000);
        step(12);

        // 6: long hold on ch0 (auto-repeat when enabled)
        raw[0] = 1'b1;
        push(10, 4'b0001, 4'b0000);
`ifdef DEBOUNCE_REPEAT_EN
        push(42, 4'b0001, 4'b0000);
        push(50, 4'b0001, 4'b0000);
        push(58, 4'b0001, 4'b0000);
`endif
        step(60);
        chk("t6_level_hold", 32'(level), 32'h1);
        raw[0] = 1'b0;
        push(10, 4'b0000, 4'b0001);
        step(12);
        chk("t6_level_rel", 32'(level), 32'h0);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
